// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte/half/word accesses to a single-ported
// word memory, with sign/zero extension and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        store_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rmw_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        req_fault;
  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [31:0] mem_addr;

  assign req_fault = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00);
  assign accept    = (state_q == S_IDLE) && req;

  // State register; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (req_fault)                         state_d = S_DONE;
          else if (is_store && size == 2'b10)    state_d = S_WRITE;
          else                                   state_d = S_READ;
        end
      end
      S_READ:  state_d = store_q ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    fault     = (state_q == S_DONE) && fault_q;
    MemRead   = (state_q == S_READ);
    // Gated by reset so an abort in WRITE can never commit a store.
    MemWrite  = (state_q == S_WRITE) && !reset;
    Address   = (state_q == S_READ || state_q == S_WRITE) ? mem_addr : 32'd0;
    WriteData = MemWrite ? merged : 32'd0;
  end

  assign mem_addr = WORD_ADDR ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};

  assign ld_byte = ReadData[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = ReadData[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   load_val = {{16{sext_q & ld_half[15]}}, ld_half};
      default: load_val = ReadData;
    endcase
  end

  always_comb begin
    merged = rmw_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Request latch and read capture; rdata only moves on a completed load.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_q <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rmw_q   <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        store_q <= is_store;
        size_q  <= size;
        sext_q  <= sign_ext;
        addr_q  <= addr;
        wdata_q <= wdata;
        fault_q <= req_fault;
      end
      if (state_q == S_READ) begin
        if (store_q) rmw_q   <= ReadData;
        else         rdata_q <= load_val;
      end
    end
  end

  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 16-word behavioural memory.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req;
  logic        is_store;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [1:0]  dbg_state;

  logic [31:0] mem [0:15];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int overlap_cnt = 0;
  int idle_access_cnt = 0;

  int          lat, nrd, nwr;
  logic [31:0] rd_addr, wr_data, got_rdata;
  logic        got_fault;

  load_store_unit #(.WORD_ADDR(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .fault(fault), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .dbg_state_o(dbg_state)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ReadData = mem[Address[3:0]];

  always @(posedge clk) begin
    if (MemWrite)    mem[Address[3:0]] <= WriteData;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  always @(negedge clk) begin
    if (MemRead && MemWrite) overlap_cnt++;
    if (!busy && (MemRead || MemWrite)) idle_access_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    next_cycle();
    pre_we = 1'b0;
  endtask

  // One request pulse, then scrambled inputs; records what the memory side saw.
  task automatic access(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    lat = 0; nrd = 0; nwr = 0; rd_addr = '0; wr_data = '0;
    got_rdata = '0; got_fault = 1'b0;
    next_cycle();
    req = 1'b0; is_store = ~st; size = ~sz; sign_ext = ~sx; addr = ~a; wdata = ~wd;
    for (int i = 1; i <= 8; i++) begin
      #1;
      if (MemRead)  begin nrd++; rd_addr = Address; end
      if (MemWrite) begin nwr++; wr_data = WriteData; end
      if (done) begin
        lat = i; got_rdata = rdata; got_fault = fault;
        next_cycle();
        break;
      end
      next_cycle();
    end
  endtask

  initial begin
    int dcnt, first_d, last_d;
    reset = 1'b1; req = 1'b0; is_store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    next_cycle();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_ctl", {30'd0, MemRead, MemWrite}, 32'd0);
    check("rst_address", Address, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    next_cycle();
    reset = 1'b0;
    preload(4'd3, 32'h5555_5540);
    preload(4'd7, 32'h1122_3344);

    access(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0);
    check("lw_lat", lat, 32'd2);
    check("lw_nrd", nrd, 32'd1);
    check("lw_addr", rd_addr, 32'd3);
    check("lw_nwr", nwr, 32'd0);
    check("lw_rdata", got_rdata, 32'h5555_5540);
    check("lw_fault", {31'd0, got_fault}, 32'd0);
    check("lw_held", rdata, 32'h5555_5540);

    access(1'b0, 2'b00, 1'b1, 32'h0000_000C, 32'h0);
    check("lb0_rdata", got_rdata, 32'h0000_0040);
    access(1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0);
    check("lb3_rdata", got_rdata, 32'h0000_0055);

    preload(4'd3, 32'h0000_8000);
    access(1'b0, 2'b01, 1'b1, 32'h0000_000C, 32'h0);
    check("lh_sx_rdata", got_rdata, 32'hFFFF_8000);
    check("lh_sx_lat", lat, 32'd2);
    access(1'b0, 2'b01, 1'b0, 32'h0000_000C, 32'h0);
    check("lhu_rdata", got_rdata, 32'h0000_8000);
    access(1'b0, 2'b00, 1'b1, 32'h0000_000D, 32'h0);
    check("lb1_sx_rdata", got_rdata, 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0);
    check("lbu1_rdata", got_rdata, 32'h0000_0080);

    access(1'b1, 2'b00, 1'b0, 32'h0000_001D, 32'h0000_00AB);
    check("sb_lat", lat, 32'd3);
    check("sb_nrd", nrd, 32'd1);
    check("sb_nwr", nwr, 32'd1);
    check("sb_wdata", wr_data, 32'h1122_AB44);
    check("sb_mem", mem[7], 32'h1122_AB44);
    access(1'b0, 2'b10, 1'b0, 32'h0000_001C, 32'h0);
    check("sb_reload", got_rdata, 32'h1122_AB44);

    access(1'b0, 2'b10, 1'b0, 32'h0000_000E, 32'h0);
    check("lw_mis_lat", lat, 32'd1);
    check("lw_mis_fault", {31'd0, got_fault}, 32'd1);
    check("lw_mis_mem", nrd + nwr, 32'd0);
    check("lw_mis_rdata", got_rdata, 32'h1122_AB44);
    access(1'b1, 2'b01, 1'b0, 32'h0000_000D, 32'h0000_1234);
    check("sh_mis_lat", lat, 32'd1);
    check("sh_mis_fault", {31'd0, got_fault}, 32'd1);
    check("sh_mis_mem", nrd + nwr, 32'd0);
    access(1'b0, 2'b11, 1'b0, 32'h0000_000C, 32'h0);
    check("sz11_lat", lat, 32'd1);
    check("sz11_fault", {31'd0, got_fault}, 32'd1);
    check("sz11_mem", nrd + nwr, 32'd0);
    check("sz11_rdata", got_rdata, 32'h1122_AB44);

    access(1'b1, 2'b01, 1'b0, 32'h0000_001E, 32'h0000_BEEF);
    check("sh_lat", lat, 32'd3);
    check("sh_wdata", wr_data, 32'hBEEF_AB44);
    check("sh_mem", mem[7], 32'hBEEF_AB44);

    access(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
    check("sw_lat", lat, 32'd2);
    check("sw_nrd", nrd, 32'd0);
    check("sw_nwr", nwr, 32'd1);
    check("sw_mem", mem[8], 32'hCAFE_F00D);

    // Reset lands while the word store sits in WRITE
    req = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h0000_001C; wdata = 32'hDEAD_BEEF;
    next_cycle();
    req = 1'b0; reset = 1'b1;
    #1;
    check("abort_in_write", {30'd0, dbg_state}, 32'd2);
    check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      next_cycle();
      #1;
    end
    check("abort_no_done", dcnt, 32'd0);
    check("abort_mem", mem[7], 32'hBEEF_AB44);

    next_cycle();
    req = 1'b1; reset = 1'b1; is_store = 1'b0; size = 2'b10; addr = 32'h0000_000C;
    next_cycle();
    reset = 1'b0; req = 1'b0;
    #1;
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    check("rst_prio_rd", {31'd0, MemRead}, 32'd0);
    next_cycle();

    // Request held high: loads every third cycle
    req = 1'b1; is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h0000_000C;
    dcnt = 0; first_d = -1; last_d = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (done) begin
        dcnt++;
        if (first_d < 0) first_d = i;
        last_d = i;
      end
      next_cycle();
    end
    req = 1'b0;
    check("b2b_count", dcnt, 32'd4);
    check("b2b_first", first_d, 32'd2);
    check("b2b_last", last_d, 32'd11);
    check("b2b_rdata", rdata, 32'h0000_8000);
    next_cycle();
    next_cycle();

    check("no_rd_wr_overlap", overlap_cnt, 32'd0);
    check("no_access_idle", idle_access_cnt, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
